// File: rtl/line_buffer_param_if.sv
// Handshake bundle for line_buffer_param: pixel write port, window read
// request and the registered window/status outputs.
//   master : drives i_data, i_data_valid, i_rd_data; observes the o_* outputs
//   slave  : the line buffer itself
interface line_buffer_param_if #(
    parameter int DATA_W   = 8,
    parameter int KERNEL_W = 3
);
    logic [DATA_W-1:0]          i_data;
    logic                       i_data_valid;
    logic                       i_rd_data;
    logic [KERNEL_W*DATA_W-1:0] o_data;
    logic                       o_data_valid;
    logic                       o_full;
    logic                       o_line_done;
    logic                       o_wr_drop;

    modport master (
        output i_data, i_data_valid, i_rd_data,
        input  o_data, o_data_valid, o_full, o_line_done, o_wr_drop
    );

    modport slave (
        input  i_data, i_data_valid, i_rd_data,
        output o_data, o_data_valid, o_full, o_line_done, o_wr_drop
    );
endinterface

// File: rtl/line_buffer_param.sv
// Single-row pixel line buffer: fills one row of LINE_LEN pixels, then
// serves KERNEL_W-wide windows at stride 1, one per read, then refills.
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   bus (slave)  i_data/i_data_valid write port, i_rd_data read request,
//                o_data window (MSB slice = leftmost pixel), o_data_valid,
//                o_full, o_line_done, o_wr_drop
// Build option: define LINE_BUFFER_PAD_EN for zero-padded "same" windows
// (LINE_LEN windows centred on each pixel); otherwise "valid" windows only.
module line_buffer_param #(
    parameter int DATA_W   = 8,
    parameter int LINE_LEN = 512,
    parameter int KERNEL_W = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    line_buffer_param_if.slave bus
);

    localparam int AW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int OW = KERNEL_W * DATA_W;

`ifdef LINE_BUFFER_PAD_EN
    localparam int NUM_WIN = LINE_LEN;
    localparam int HALF    = (KERNEL_W - 1) / 2;
`else
    localparam int NUM_WIN = LINE_LEN - KERNEL_W + 1;
`endif

    localparam logic [AW-1:0] LAST_PTR = AW'(LINE_LEN - 1);
    localparam logic [AW-1:0] LAST_WIN = AW'(NUM_WIN - 1);

    typedef enum logic {
        FILL,
        READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     wr_ptr_nxt;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic              wr_en;
    logic              rd_en;
    logic              last_rd;
    logic [OW-1:0]     win;

    logic [DATA_W-1:0] line [LINE_LEN];

    logic [OW-1:0]     data_q;
    logic              valid_q;
    logic              done_q;
    logic              drop_q;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pointer updates and strobes
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        last_rd    = 1'b0;
        unique case (state)
            FILL: begin
                if (bus.i_data_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_PTR) begin
                        wr_ptr_nxt = '0;
                        state_nxt  = READY;
                    end else begin
                        wr_ptr_nxt = wr_ptr + 1'b1;
                    end
                end
            end
            READY: begin
                if (bus.i_rd_data) begin
                    rd_en = 1'b1;
                    if (rd_ptr == LAST_WIN) begin
                        last_rd    = 1'b1;
                        rd_ptr_nxt = '0;
                        state_nxt  = FILL;
                    end else begin
                        rd_ptr_nxt = rd_ptr + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Window taps. rd_ptr never exceeds NUM_WIN-1, so in valid mode the
    // rightmost tap stays within the row; in pad mode each tap is
    // range-checked and forced to zero outside the row.
    always_comb begin
        win = '0;
        for (int j = 0; j < KERNEL_W; j++) begin
`ifdef LINE_BUFFER_PAD_EN
            logic [AW+1:0] pos;
            pos = {2'b00, rd_ptr} + (AW+2)'(j);
            if (pos >= (AW+2)'(HALF) &&
                pos - (AW+2)'(HALF) < (AW+2)'(LINE_LEN)) begin
                win[(KERNEL_W-1-j)*DATA_W +: DATA_W] =
                    line[AW'(pos - (AW+2)'(HALF))];
            end
`else
            win[(KERNEL_W-1-j)*DATA_W +: DATA_W] = line[rd_ptr + AW'(j)];
`endif
        end
    end

    // Row storage is intentionally not reset
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) begin
            line[wr_ptr] <= bus.i_data;
        end
    end

    // Pointers and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            valid_q <= rd_en;
            done_q  <= last_rd;
            // A write in the final-read cycle is still seen in READY
            drop_q  <= (state == READY) && bus.i_data_valid;
            if (rd_en) begin
                data_q <= win;
            end
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_line_done  = done_q;
    assign bus.o_wr_drop    = drop_q;
    assign bus.o_full       = (state == READY);

endmodule
